// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by pipe_hazard_ctrl and hazard_perf_cnt.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } hz_state_e;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating stall/flush event counters for the hazard controller.
// Built only when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_stall_cycles,
  output logic [15:0] o_flush_count
);

  logic [31:0] r_stall;
  logic [15:0] r_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (i_stall && (r_stall != '1))
        r_stall <= r_stall + 32'd1;
      if (i_flush && (r_flush != '1))
        r_flush <= r_flush + 16'd1;
    end
  end

  assign o_stall_cycles = r_stall;
  assign o_flush_count  = r_flush;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use stall.
// Optional perf counters with macro HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic             EXMEM_Branch,
  input  logic             EXMEM_Zero,
  input  logic             EXMEM_MemRead,
  input  logic             EXMEM_MemWrite,
  input  logic             DMemReady,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             MEMWB_Bubble,
  output logic             PCSrc,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]      StallCycles,
  output logic [15:0]      FlushCount,
`endif
  output logic             Err
);

  localparam logic [7:0] LIM = WAIT_LIMIT[7:0];

  hz_state_e  r_state;
  logic [7:0] r_cnt;

  logic w_access;
  logic w_freeze;
  logic w_rst;
  logic w_fz;
  logic w_br;
  logic w_lu;
  logic w_match;

  assign w_access = EXMEM_MemRead | EXMEM_MemWrite;
  assign w_freeze = (r_state == ERR)
                  | (!DMemReady & (r_state == MEMWAIT))
                  | (!DMemReady & (r_state == RUN) & w_access);
  assign w_match  = (IDEX_Rt == IFID_Rs) | (IDEX_Rt == IFID_Rt);

  // Mutually exclusive terms so the decoder below is truly unique.
  assign w_rst = !Rst_n;
  assign w_fz  = Rst_n & w_freeze;
  assign w_br  = Rst_n & !w_freeze & EXMEM_Branch & EXMEM_Zero;
  assign w_lu  = Rst_n & !w_freeze & !w_br & IDEX_MemRead
               & (IDEX_Rt != ZERO_REG) & w_match;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_access && !DMemReady) begin
            r_state <= MEMWAIT;
            r_cnt   <= '0;
          end
        end
        MEMWAIT: begin
          if (DMemReady) begin
            r_state <= RUN;
          end else if (r_cnt + 8'd1 == LIM) begin
            r_state <= ERR;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ERR;
      endcase
    end
  end

  always_comb begin
    {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write} = 4'b1111;
    {IFID_Flush, IDEX_Flush, EXMEM_Flush} = 3'b000;
    MEMWB_Bubble = 1'b0;
    PCSrc        = 1'b0;
    unique case (1'b1)
      w_rst: begin
        {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write} = 4'b0000;
        {IFID_Flush, IDEX_Flush, EXMEM_Flush} = 3'b111;
        MEMWB_Bubble = 1'b1;
      end
      w_fz: begin
        {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write} = 4'b0000;
        MEMWB_Bubble = 1'b1;
      end
      w_br: begin
        {IFID_Flush, IDEX_Flush, EXMEM_Flush} = 3'b111;
        PCSrc = 1'b1;
      end
      w_lu: begin
        PCWrite    = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign Err = (r_state == ERR);

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk            (Clk),
    .rst_n          (Rst_n),
    .i_stall        (w_fz | w_lu),
    .i_flush        (w_br),
    .o_stall_cycles (StallCycles),
    .o_flush_count  (FlushCount)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl, WAIT_LIMIT = 4.
// Counter ports checked when HAZARD_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [4:0] IFID_Rs = '0;
  logic [4:0] IFID_Rt = '0;
  logic       IDEX_MemRead = 1'b0;
  logic [4:0] IDEX_Rt = '0;
  logic       EXMEM_Branch = 1'b0;
  logic       EXMEM_Zero = 1'b0;
  logic       EXMEM_MemRead = 1'b0;
  logic       EXMEM_MemWrite = 1'b0;
  logic       DMemReady = 1'b0;
  logic       PCWrite, IFID_Write, IDEX_Write, EXMEM_Write;
  logic       IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Bubble;
  logic       PCSrc, Err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles;
  logic [15:0] FlushCount;
`endif

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.WAIT_LIMIT(4)) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .IFID_Rs        (IFID_Rs),
    .IFID_Rt        (IFID_Rt),
    .IDEX_MemRead   (IDEX_MemRead),
    .IDEX_Rt        (IDEX_Rt),
    .EXMEM_Branch   (EXMEM_Branch),
    .EXMEM_Zero     (EXMEM_Zero),
    .EXMEM_MemRead  (EXMEM_MemRead),
    .EXMEM_MemWrite (EXMEM_MemWrite),
    .DMemReady      (DMemReady),
    .PCWrite        (PCWrite),
    .IFID_Write     (IFID_Write),
    .IDEX_Write     (IDEX_Write),
    .EXMEM_Write    (EXMEM_Write),
    .IFID_Flush     (IFID_Flush),
    .IDEX_Flush     (IDEX_Flush),
    .EXMEM_Flush    (EXMEM_Flush),
    .MEMWB_Bubble   (MEMWB_Bubble),
    .PCSrc          (PCSrc),
`ifdef HAZARD_PERF_CNT_EN
    .StallCycles    (StallCycles),
    .FlushCount     (FlushCount),
`endif
    .Err            (Err)
  );

  // {PCWrite,IFID_W,IDEX_W,EXMEM_W, IFID_F,IDEX_F,EXMEM_F,Bubble, PCSrc, Err}
  localparam logic [9:0] NORM = 10'b1111_0000_0_0;
  localparam logic [9:0] FRZ  = 10'b0000_0001_0_0;
  localparam logic [9:0] ERRV = 10'b0000_0001_0_1;
  localparam logic [9:0] BR   = 10'b1111_1110_1_0;
  localparam logic [9:0] LU   = 10'b0011_0100_0_0;
  localparam logic [9:0] RST  = 10'b0000_1111_0_0;

  typedef struct {
    string       nm;
    logic [9:0]  v;
    logic [31:0] st;
    logic [15:0] fl;
  } exp_t;

  exp_t q[$];
  int n_run  = 0;
  int n_fail = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic drv(input string nm, input logic rst,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic ldr, input logic [4:0] ldrt,
                     input logic br, input logic z,
                     input logic mr, input logic mw, input logic rdy,
                     input logic [9:0] e);
    exp_t x;
    @(posedge Clk);
    #1;
    Rst_n          = ~rst;
    IFID_Rs        = rs;
    IFID_Rt        = rt;
    IDEX_MemRead   = ldr;
    IDEX_Rt        = ldrt;
    EXMEM_Branch   = br;
    EXMEM_Zero     = z;
    EXMEM_MemRead  = mr;
    EXMEM_MemWrite = mw;
    DMemReady      = rdy;
    if (rst) begin
      m_stall = 0;
      m_flush = 0;
    end
    x.nm = nm;
    x.v  = e;
    x.st = 32'(m_stall);
    x.fl = 16'(m_flush);
    q.push_back(x);
    if (!rst) begin
      if (e == FRZ || e == ERRV || e == LU) m_stall++;
      if (e == BR) m_flush++;
    end
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [9:0] a;
      x = q.pop_front();
      a = {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write,
           IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Bubble,
           PCSrc, Err};
      n_run++;
      if (a !== x.v) begin
        n_fail++;
        $display("FAIL %s: outputs got %b want %b", x.nm, a, x.v);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_run++;
      if (StallCycles !== x.st) begin
        n_fail++;
        $display("FAIL %s: StallCycles got %0d want %0d",
                 x.nm, StallCycles, x.st);
      end
      n_run++;
      if (FlushCount !== x.fl) begin
        n_fail++;
        $display("FAIL %s: FlushCount got %0d want %0d",
                 x.nm, FlushCount, x.fl);
      end
`endif
    end
  end

  initial begin
    //   name          rst rs  rt  ldr ldrt br z mr mw rdy exp
    drv("reset0",     1, 0,  0,  0, 0,  0, 0, 0, 0, 0, RST);
    drv("reset1",     1, 0,  0,  0, 0,  0, 0, 1, 0, 0, RST);
    drv("idle",       0, 0,  0,  0, 0,  0, 0, 0, 0, 0, NORM);
    drv("lu_rs",      0, 8,  3,  1, 8,  0, 0, 0, 0, 0, LU);
    drv("lu_after",   0, 8,  3,  0, 8,  0, 0, 0, 0, 0, NORM);
    drv("lu_rt",      0, 2,  8,  1, 8,  0, 0, 0, 0, 1, LU);
    drv("lu_r0",      0, 0,  0,  1, 0,  0, 0, 0, 0, 0, NORM);
    drv("lu_nomatch", 0, 3,  4,  1, 8,  0, 0, 0, 0, 0, NORM);
    drv("br_taken",   0, 0,  0,  0, 0,  1, 1, 0, 0, 0, BR);
    drv("br_after",   0, 0,  0,  0, 0,  0, 0, 0, 0, 0, NORM);
    drv("br_nz",      0, 0,  0,  0, 0,  1, 0, 0, 0, 0, NORM);
    drv("br_plus_lu", 0, 8,  0,  1, 8,  1, 1, 0, 0, 0, BR);
    drv("mw_f1",      0, 0,  0,  0, 0,  0, 0, 1, 0, 0, FRZ);
    drv("mw_f2",      0, 0,  0,  0, 0,  0, 0, 1, 0, 0, FRZ);
    drv("mw_f3",      0, 0,  0,  0, 0,  0, 0, 1, 0, 0, FRZ);
    drv("mw_rel",     0, 0,  0,  0, 0,  0, 0, 1, 0, 1, NORM);
    drv("mw_run",     0, 0,  0,  0, 0,  0, 0, 0, 0, 0, NORM);
    drv("brfz_f1",    0, 8,  0,  1, 8,  1, 1, 0, 1, 0, FRZ);
    drv("brfz_f2",    0, 8,  0,  1, 8,  1, 1, 0, 1, 0, FRZ);
    drv("brfz_rel",   0, 8,  0,  1, 8,  1, 1, 0, 1, 1, BR);
    drv("brfz_after", 0, 0,  0,  0, 0,  0, 0, 0, 0, 0, NORM);
    drv("to_run",     0, 0,  0,  0, 0,  0, 0, 1, 0, 0, FRZ);
    drv("to_w1",      0, 0,  0,  0, 0,  0, 0, 1, 0, 0, FRZ);
    drv("to_w2",      0, 0,  0,  0, 0,  0, 0, 1, 0, 0, FRZ);
    drv("to_w3",      0, 0,  0,  0, 0,  0, 0, 1, 0, 0, FRZ);
    drv("to_w4",      0, 0,  0,  0, 0,  0, 0, 1, 0, 0, FRZ);
    drv("to_err",     0, 0,  0,  0, 0,  0, 0, 1, 0, 0, ERRV);
    drv("err_rdy",    0, 0,  0,  0, 0,  0, 0, 0, 0, 1, ERRV);
    drv("err_br",     0, 8,  0,  1, 8,  1, 1, 0, 0, 1, ERRV);
    drv("err_rst",    1, 0,  0,  0, 0,  0, 0, 0, 0, 0, RST);
    drv("err_clear",  0, 0,  0,  0, 0,  0, 0, 0, 0, 0, NORM);
    drv("br_cnt",     0, 0,  0,  0, 0,  1, 1, 0, 0, 0, BR);
    drv("mr_f1",      0, 0,  0,  0, 0,  0, 0, 1, 0, 0, FRZ);
    drv("mr_f2",      0, 0,  0,  0, 0,  0, 0, 1, 0, 0, FRZ);
    drv("mr_rst",     1, 0,  0,  0, 0,  0, 0, 1, 0, 0, RST);
    drv("mr_rel",     0, 0,  0,  0, 0,  0, 0, 1, 0, 1, NORM);
    drv("mr_idle",    0, 0,  0,  0, 0,  0, 0, 0, 0, 0, NORM);
    drv("mr_lu",      0, 5,  0,  1, 5,  0, 0, 0, 0, 0, LU);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
